// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, wait-counter width, DRW encodings, alignment helper.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Wide enough for the largest legal wait-state count (15).
   localparam int CNT_W = 4;

   localparam logic DRW_READ  = 1'b0;
   localparam logic DRW_WRITE = 1'b1;

   // Any non-zero byte offset within the word is a misaligned access.
   function automatic logic is_misaligned(input logic [1:0] i_lsb);
      return |i_lsb;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port 2^AW x 32 word RAM with synchronous write and registered read.
// Latency: read data appears on the edge that performs the access.
// Backpressure: none; accepts an access whenever i_we or i_re is high.
// Ports: i_clk/i_rst clock and async active-high reset (read register only),
//        i_we/i_re access strobes, i_rd_zero forces the read register to 0,
//        i_addr word index, i_wdata write data, o_rdata registered read data.
module dmem_array #(
   parameter int AW = 10
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_we,
   input  logic          i_re,
   input  logic          i_rd_zero,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [2**AW];
   logic [31:0] r_rdata;

   // Storage has no reset so it maps onto a plain RAM macro.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   // Read register holds its value between reads.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= i_rd_zero ? 32'h0 : r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one active-low word request at a time, LAT wait states, then a DRDY pulse.
// Latency: DREQ low in IDLE at cycle n gives DRDY in cycle n+LAT+1; one access per LAT+2 cycles.
// Backpressure: DSTALL holds the pipeline from request acceptance until the RESP cycle.
// Ports: CLK, RST (async active-high); DREQ/DRW/DADDR/DWDATA request; DRDATA/DRDY/DSTALL/DERR response.
// Build option: define DMEM_ERR_CHECK_EN to flag misaligned accesses on DERR and suppress their effect.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int AW  = 10,
   parameter int LAT = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        DREQ,
   input  logic        DRW,
   input  logic [31:0] DADDR,
   input  logic [31:0] DWDATA,
   output logic [31:0] DRDATA,
   output logic        DRDY,
   output logic        DSTALL,
   output logic        DERR
);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_wr;
   logic [AW-1:0]    r_idx;
   logic [31:0]      r_wdata;
   logic             r_mis;
   logic             r_drdy;
   logic             r_derr;

   logic             w_mis_req;
   logic             w_access;
   logic             w_mem_we;
   logic             w_mem_re;
   logic             w_unused_addr;

`ifdef DMEM_ERR_CHECK_EN
   assign w_mis_req     = is_misaligned(DADDR[1:0]);
   assign w_unused_addr = ^DADDR[31:AW+2];
`else
   // Byte offset is ignored entirely; DERR can never be raised.
   assign w_mis_req     = 1'b0;
   assign w_unused_addr = ^{DADDR[31:AW+2], DADDR[1:0]};
`endif

   // The access happens on the edge that leaves WAIT for RESP.
   assign w_access = (r_state == WAIT) && (r_cnt == '0);
   assign w_mem_we = w_access && r_wr && !r_mis;
   assign w_mem_re = w_access && !r_wr;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_wr    <= DRW_READ;
         r_idx   <= '0;
         r_wdata <= '0;
         r_mis   <= 1'b0;
         r_drdy  <= 1'b0;
         r_derr  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_drdy <= 1'b0;
               r_derr <= 1'b0;
               if (!DREQ) begin
                  r_wr    <= (DRW == DRW_WRITE);
                  r_idx   <= DADDR[AW+1:2];
                  r_wdata <= DWDATA;
                  r_mis   <= w_mis_req;
                  r_cnt   <= CNT_W'(LAT - 1);
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (r_cnt == '0) begin
                  r_drdy  <= 1'b1;
                  r_derr  <= r_mis;
                  r_state <= RESP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            RESP: begin
               // DREQ is still the old request here; it must not relaunch.
               r_drdy  <= 1'b0;
               r_derr  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_drdy  <= 1'b0;
               r_derr  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   dmem_array #(
      .AW (AW)
   ) u_array (
      .i_clk     (CLK),
      .i_rst     (RST),
      .i_we      (w_mem_we),
      .i_re      (w_mem_re),
      .i_rd_zero (r_mis),
      .i_addr    (r_idx),
      .i_wdata   (r_wdata),
      .o_rdata   (DRDATA)
   );

   // Combinational so the pipeline is released in the RESP cycle itself.
   assign DSTALL = ((r_state == IDLE) && !DREQ) || (r_state == WAIT);
   assign DRDY   = r_drdy;
   assign DERR   = r_derr;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam int AW  = 10;
   localparam int LAT = 2;
`ifdef DMEM_ERR_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        DREQ = 1'b1;
   logic        DRW = 1'b0;
   logic [31:0] DADDR = '0;
   logic [31:0] DWDATA = '0;
   logic [31:0] DRDATA;
   logic        DRDY;
   logic        DSTALL;
   logic        DERR;

   dmem_responder #(.AW(AW), .LAT(LAT)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .DREQ   (DREQ),
      .DRW    (DRW),
      .DADDR  (DADDR),
      .DWDATA (DWDATA),
      .DRDATA (DRDATA),
      .DRDY   (DRDY),
      .DSTALL (DSTALL),
      .DERR   (DERR)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int          acc;
      int          rdy;
      logic [31:0] rdata;
      bit          err;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mmem [int];
   logic [31:0] last_rd = '0;
   logic [31:0] cur_exp = '0;
   int          last_rdy = 0;
   int          checks = 0;
   int          fails = 0;
   bit          done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on each expected completion.
   always @(negedge CLK) begin
      if (RST) begin
         cur_exp = '0;
      end else begin
         bit exp_rdy;
         bit exp_stall;
         bit exp_err;
         exp_rdy   = (sb.size() > 0) && (sb[0].rdy == cyc);
         exp_stall = (sb.size() > 0) && (cyc >= sb[0].acc) && (cyc < sb[0].rdy);
         exp_err   = 1'b0;
         chk("DRDY", {31'b0, DRDY}, {31'b0, exp_rdy});
         chk("DSTALL", {31'b0, DSTALL}, {31'b0, exp_stall});
         if (exp_rdy) begin
            exp_t e;
            e = sb.pop_front();
            cur_exp = e.rdata;
            exp_err = e.err;
         end
         chk("DERR", {31'b0, DERR}, {31'b0, exp_err});
         chk("DRDATA", DRDATA, cur_exp);
      end
   end

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) & ((32'd1 << AW) - 1));
   endfunction

   // Called at #1 after a rising edge. Returns in the RESP cycle.
   task automatic issue(input bit rw, input logic [31:0] addr, input logic [31:0] wd, input bit hold);
      exp_t e;
      int   idx;
      bit   mis;
      DREQ = 1'b0; DRW = rw; DADDR = addr; DWDATA = wd;
      e.acc = (cyc > last_rdy) ? cyc : last_rdy + 1;
      e.rdy = e.acc + LAT + 1;
      idx = widx(addr);
      mis = ERR_EN && (addr[1:0] != 2'b00);
      e.err = mis;
      if (rw) begin
         if (!mis) mmem[idx] = wd;
         e.rdata = last_rd;
      end else begin
         e.rdata = mis ? 32'h0 : mmem[idx];
         last_rd = e.rdata;
      end
      sb.push_back(e);
      last_rdy = e.rdy;
      while (cyc <= e.acc) begin @(posedge CLK); #1; end
      // Request is captured; inputs are now irrelevant until IDLE.
      DRW = 1'($urandom); DADDR = $urandom; DWDATA = $urandom;
      while (cyc < e.rdy) begin @(posedge CLK); #1; end
      if (!hold) DREQ = 1'b1;
   endtask

   task automatic abort_write(input logic [31:0] addr, input logic [31:0] wd);
      exp_t e;
      @(posedge CLK); #1;
      DREQ = 1'b0; DRW = 1'b1; DADDR = addr; DWDATA = wd;
      e.acc = cyc; e.rdy = cyc + LAT + 1; e.rdata = last_rd; e.err = 1'b0;
      sb.push_back(e);
      @(posedge CLK); #1;
      RST = 1'b1; DREQ = 1'b1;
      sb.delete();
      last_rd = '0;
      repeat (2) begin @(posedge CLK); #1; end
      RST = 1'b0;
      last_rdy = 0;
   endtask

   initial begin
      logic [31:0] amask;
      amask = ~((((32'd1 << AW) - 1) << 2) | 32'd3);
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      repeat (10) begin @(posedge CLK); #1; end

      issue(1'b1, 32'h40, 32'hDEADBEEF, 1'b0);
      issue(1'b0, 32'h40, 32'h0, 1'b0);
      issue(1'b1, 32'h1000, 32'h11, 1'b0);
      issue(1'b0, 32'h0000, 32'h0, 1'b0);
      issue(1'b1, 32'h41, 32'h55, 1'b0);
      issue(1'b0, 32'h40, 32'h0, 1'b0);
      issue(1'b0, 32'h43, 32'h0, 1'b0);

      issue(1'b1, 32'h80, 32'hCAFE0080, 1'b0);
      abort_write(32'h80, 32'h77);
      issue(1'b0, 32'h80, 32'h0, 1'b0);

      // Back-to-back with DREQ held low across RESP.
      issue(1'b1, 32'h84, 32'hA0A0A0A0, 1'b1);
      issue(1'b0, 32'h84, 32'h0, 1'b1);
      issue(1'b1, 32'h88, 32'h12345678, 1'b1);
      issue(1'b0, 32'h80, 32'h0, 1'b1);
      issue(1'b0, 32'h88, 32'h0, 1'b0);

      for (int i = 0; i < 150; i++) begin
         bit          rw;
         bit          hold;
         logic [31:0] a;
         int          idx;
         rw  = 1'($urandom);
         idx = $urandom_range(0, 31);
         a   = ($urandom & amask) | (32'(idx) << 2);
         if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
         if (!rw && !mmem.exists(widx(a))) rw = 1'b1;
         hold = (i != 149) && ($urandom_range(0, 1) == 1);
         issue(rw, a, $urandom, hold);
         if (!hold) repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
      end

      for (int k = 0; k < 20 && sb.size() != 0; k++) begin @(posedge CLK); #1; end
      repeat (3) begin @(posedge CLK); #1; end
      checks++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
      end
      done = 1'b1;
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

   initial begin
      #300000;
      if (!done) begin
         checks++;
         fails++;
         $display("FAIL watchdog: run did not complete by cycle %0d", cyc);
         $display("%0d/%0d checks passed", checks - fails, checks);
         $finish;
      end
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC_toy pipeline: the far end of the DREQ/DRW request that the decode/execute pipeline registers carry toward the memory stage. It accepts one active-low word request at a time, inserts a fixed number of wait states, commits writes, and returns read data. While a request is in flight it asserts a stall to the pipeline, and it pulses a one-cycle ready on completion.

## Interface
- AW, 10: word-address bits; the array holds 2^AW 32-bit words.
- LAT, 2: wait-state cycles per access; legal range 1..15.
- CLK  in  1  single clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- DREQ  in  1  request, active low; 1 = idle.
- DRW  in  1  1 = write, 0 = read; sampled only with DREQ = 0.
- DADDR  in  32  byte address; word index is DADDR[AW+1:2].
- DWDATA  in  32  write data.
- DRDATA  out  32  read data, registered.
- DRDY  out  1  one-cycle completion pulse.
- DSTALL  out  1  pipeline hold request.
- DERR  out  1  misaligned-access flag, valid with DRDY.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If DREQ = 0, capture DADDR, DWDATA and DRW into request registers.
  - Load the wait counter with LAT-1 and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If the counter is 0, go to RESP and perform the access on that edge.
    - Read: DRDATA <= mem[index].
    - Write: mem[index] <= captured data; DRDATA is unchanged.
  - Otherwise decrement the counter and stay in WAIT.
- RESP:
  - DRDY = 1 for exactly this cycle, then go to IDLE unconditionally.
  - DREQ is ignored in RESP, because the stalled pipeline still presents the same request during this cycle.
- DSTALL = (IDLE and DREQ = 0) or WAIT. It is combinational and is 0 in RESP, so the pipeline advances on the RESP edge.
- Address bits above AW+1 are ignored, so addresses wrap modulo 2^AW words.
- DRDATA holds its value until the next completed read.
- Inputs may change while in WAIT without effect, because all request fields were captured in IDLE.

## Timing
- Reset values: state IDLE, DRDATA 0, DRDY 0, DERR 0, wait counter 0.
- Memory contents are not reset.
- Reset asserted mid-access aborts it: a pending write is discarded and no DRDY is issued.
- Latency: DREQ low in IDLE in cycle n gives DRDY = 1 in cycle n+LAT+1 (LAT=2 gives cycle n+3).
- Read data is valid from the DRDY cycle onward.
- Throughput: one access per LAT+2 cycles. The earliest next request is seen in IDLE, one cycle after RESP.
- A write followed by a read of the same word returns the new data.

## Configuration
- DMEM_ERR_CHECK_EN defined:
  - A request with DADDR[1:0] != 0 still runs the full IDLE/WAIT/RESP sequence.
  - A misaligned write is suppressed.
  - A misaligned read loads DRDATA with 0.
  - DERR = 1 in the RESP cycle, 0 otherwise.
- DMEM_ERR_CHECK_EN undefined:
  - DADDR[1:0] is ignored and the access uses the word index.
  - DERR is tied to 0.

## Structure
- Shared package dmem_pkg:
  - State enum (IDLE, WAIT, RESP).
  - Wait-counter width constant (4 bits).
  - DRW encodings DRW_READ = 0, DRW_WRITE = 1.
- Sub-module dmem_array:
  - Single-port word RAM, 2^AW x 32.
  - Synchronous write, read data registered on the access edge.
  - Instantiated once.
- The FSM, counter, request registers and stall logic live in dmem_responder.

## Test plan
- Reset then idle: RST pulse with DREQ = 1 held for 10 cycles. Required: DRDY, DSTALL and DERR stay 0; DRDATA = 0.
- Write then read, LAT = 2:
  - Write 0xDEADBEEF to 0x40: DSTALL is 1 for 3 cycles and DRDY pulses in cycle n+3.
  - Read 0x40: DRDATA = 0xDEADBEEF in its DRDY cycle.
- Wrap, AW = 10: write 0x11 to 0x1000, then read 0x0000. Required: 0x11.
- Misaligned, with DMEM_ERR_CHECK_EN:
  - Write 0x55 to 0x41: DERR = 1 with DRDY.
  - Read 0x40: returns the prior value, unchanged.
  - Read 0x43: DRDATA = 0 and DERR = 1.
- Reset mid-access: assert RST during WAIT of a write of 0x77 to 0x80. Required: no DRDY; a later read of 0x80 returns the old contents.
- Back-to-back with DREQ held low across RESP: exactly one DRDY per LAT+2 cycles. For LAT = 1: DRDY every 3 cycles, and DSTALL = 0 only in RESP cycles.
